// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single main-memory port between the I-cache refill engine (IF
// stage) and the D-cache refill / write-back engine (MA stage). One requester
// owns the port at a time; simultaneous requests alternate round-robin. Each
// grant runs a LINE_WORDS-beat burst over a req/ack handshake. The bus then
// spends one DONE cycle and one IDLE cycle before the next grant.
//
// Ports
//   Clk, Rst          clock (rising edge) and asynchronous active-low reset
//   i_ic_req/addr     I-cache refill request (level) and miss address
//   o_ic_data/valid   refill word, valid one cycle after its memory ack
//   o_ic_done         one-cycle pulse when the I burst completes
//   i_dc_req/we/addr  D-cache request (level), 1 = write-back, line address
//   i_dc_wdata        current write-back word (passed straight to memory)
//   o_dc_wnext        write word consumed this cycle; show the next one
//   o_dc_data/valid   refill word, valid one cycle after its memory ack
//   o_dc_done         one-cycle pulse when the D burst completes
//   o_mem_req/we      memory beat request and write enable
//   o_mem_addr/wdata  beat byte address and write data
//   i_mem_ack/rdata   beat accepted; read data valid with the ack
//   o_grant           current owner: 01 = I, 10 = D, 00 = none
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    // I-cache side
    input  logic              i_ic_req,
    input  logic [ADDR_W-1:0] i_ic_addr,
    output logic [DATA_W-1:0] o_ic_data,
    output logic              o_ic_valid,
    output logic              o_ic_done,
    // D-cache side
    input  logic              i_dc_req,
    input  logic              i_dc_we,
    input  logic [ADDR_W-1:0] i_dc_addr,
    input  logic [DATA_W-1:0] i_dc_wdata,
    output logic              o_dc_wnext,
    output logic [DATA_W-1:0] o_dc_data,
    output logic              o_dc_valid,
    output logic              o_dc_done,
    // Memory side
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    // Ownership
    output logic [1:0]        o_grant
);

    // Beat counter width and the byte-offset mask that clears a line base.
    localparam int                CNT_W    = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

    // FSM encoding.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_I_RD = 3'd1;
    localparam logic [2:0] ST_D_RD = 3'd2;
    localparam logic [2:0] ST_D_WR = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // last_grant encoding; it also names the owner during a burst and DONE.
    localparam logic LG_I = 1'b0;
    localparam logic LG_D = 1'b1;

    logic [2:0]        state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [ADDR_W-1:0] base_q,       base_d;
    logic              last_grant_q, last_grant_d;
    logic              ic_valid_q,   ic_valid_d;
    logic [DATA_W-1:0] ic_data_q,    ic_data_d;
    logic              dc_valid_q,   dc_valid_d;
    logic [DATA_W-1:0] dc_data_q,    dc_data_d;

    logic take_ic_s;
    logic take_dc_s;
    logic burst_s;
    logic in_i_rd_s;
    logic in_d_rd_s;
    logic in_d_wr_s;
    logic in_done_s;

    assign in_i_rd_s = (state_q == ST_I_RD);
    assign in_d_rd_s = (state_q == ST_D_RD);
    assign in_d_wr_s = (state_q == ST_D_WR);
    assign in_done_s = (state_q == ST_DONE);
    assign burst_s   = in_i_rd_s | in_d_rd_s | in_d_wr_s;

    // Arbitration: a lone requester wins; on contention the side that did
    // not win last time is served.
    always_comb begin
        take_ic_s = 1'b0;
        take_dc_s = 1'b0;
        if (i_ic_req && i_dc_req) begin
            if (last_grant_q == LG_I) begin
                take_dc_s = 1'b1;
            end else begin
                take_ic_s = 1'b1;
            end
        end else if (i_dc_req) begin
            take_dc_s = 1'b1;
        end else if (i_ic_req) begin
            take_ic_s = 1'b1;
        end else begin
            take_ic_s = 1'b0;
            take_dc_s = 1'b0;
        end
    end

    // Next-state logic: grant in IDLE, count acked beats, one DONE cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (take_dc_s) begin
                    state_d      = i_dc_we ? ST_D_WR : ST_D_RD;
                    base_d       = i_dc_addr & ~OFF_MASK;
                    cnt_d        = CNT_ZERO;
                    last_grant_d = LG_D;
                end else if (take_ic_s) begin
                    state_d      = ST_I_RD;
                    base_d       = i_ic_addr & ~OFF_MASK;
                    cnt_d        = CNT_ZERO;
                    last_grant_d = LG_I;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_I_RD, ST_D_RD, ST_D_WR: begin
                // Without an ack everything holds, so no beat is ever skipped.
                if (i_mem_ack) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = CNT_ZERO;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Read return path: capture the acked word for the owning side only; the
    // other side's data register keeps its previous contents.
    always_comb begin
        ic_valid_d = in_i_rd_s & i_mem_ack;
        dc_valid_d = in_d_rd_s & i_mem_ack;
        if (ic_valid_d) begin
            ic_data_d = i_mem_rdata;
        end else begin
            ic_data_d = ic_data_q;
        end
        if (dc_valid_d) begin
            dc_data_d = i_mem_rdata;
        end else begin
            dc_data_d = dc_data_q;
        end
    end

    // State, counter, latched line base and round-robin history.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            base_q       <= {ADDR_W{1'b0}};
            last_grant_q <= LG_I;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Registered read data and valids returned to the caches.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ic_valid_q <= 1'b0;
            ic_data_q  <= {DATA_W{1'b0}};
            dc_valid_q <= 1'b0;
            dc_data_q  <= {DATA_W{1'b0}};
        end else begin
            ic_valid_q <= ic_valid_d;
            ic_data_q  <= ic_data_d;
            dc_valid_q <= dc_valid_d;
            dc_data_q  <= dc_data_d;
        end
    end

    // Memory-side outputs are decoded from the state flop, so an async reset
    // drops o_mem_req at once. Address and write data read as zero when idle.
    assign o_mem_req   = burst_s;
    assign o_mem_we    = in_d_wr_s;
    assign o_mem_addr  = burst_s ? (base_q + ADDR_W'({cnt_q, 2'b00})) : {ADDR_W{1'b0}};
    assign o_mem_wdata = in_d_wr_s ? i_dc_wdata : {DATA_W{1'b0}};
    assign o_dc_wnext  = in_d_wr_s & i_mem_ack;

    // Owner stays visible through DONE so the done pulse has a named owner.
    assign o_grant = (burst_s | in_done_s) ? ((last_grant_q == LG_D) ? 2'b10 : 2'b01) : 2'b00;

    // Done coincides with the last read valid because DONE follows the last ack.
    assign o_ic_done = in_done_s & (last_grant_q == LG_I);
    assign o_dc_done = in_done_s & (last_grant_q == LG_D);

    assign o_ic_valid = ic_valid_q;
    assign o_ic_data  = ic_data_q;
    assign o_dc_valid = dc_valid_q;
    assign o_dc_data  = dc_data_q;

endmodule
